// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the up2_timer controller.
//   state_t      - controller state encoding (SETUP, RUN, PAUSE, DONE)
//   UNITS_MOD/W  - modulus and width of a units digit (0..9)
//   TENS_MOD/W   - modulus and width of a tens digit (0..5)
package timer_pkg;

   typedef enum logic [1:0] {
      SETUP = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int UNITS_MOD = 10;
   localparam int UNITS_W   = 4;
   localparam int TENS_MOD  = 6;
   localparam int TENS_W    = 3;

endpackage

// File: rtl/up2_digit.sv
// up2_digit: synchronous modulo-N digit counter with up/down enables.
//   CLK, RST_N  - clock, asynchronous active-low reset
//   EN_INC      - count up one step (wraps N-1 -> 0)
//   EN_DEC      - count down one step (wraps 0 -> N-1)
//   CLR         - synchronous clear, highest priority
//   Q           - current digit value
//   TC_UP       - combinational carry out: Q = N-1 while EN_INC
//   TC_DN       - combinational borrow out: Q = 0 while EN_DEC
// The terminal-count outputs let the parent chain digits so a whole
// carry/borrow ripple settles within one clock cycle.
module up2_digit #(
   parameter int N    = 10,
   parameter int SIZE = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            EN_INC,
   input  logic            EN_DEC,
   input  logic            CLR,
   output logic [SIZE-1:0] Q,
   output logic            TC_UP,
   output logic            TC_DN
);

   localparam logic [SIZE-1:0] TOP = SIZE'(N - 1);

   assign TC_UP = EN_INC && (Q == TOP);
   assign TC_DN = EN_DEC && (Q == '0);

   // NOTE: sequential state is written with non-blocking assignments only,
   // so every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Q <= '0;
      end else if (CLR) begin
         Q <= '0;
      end else if (EN_INC) begin
         Q <= (Q == TOP) ? '0 : Q + 1'b1;
      end else if (EN_DEC) begin
         Q <= (Q == '0) ? TOP : Q - 1'b1;
      end
   end

endmodule

// File: rtl/up2_timer_ctrl.sv
// up2_timer_ctrl: MM:SS countdown timer controller.
//   TICK_DIV    - CLK cycles per one-second tick (>= 2)
//   DIV_W       - prescaler width, >= clog2(TICK_DIV)
//   CLK, RST_N  - clock, asynchronous active-low reset
//   BTN_START   - start / pause / resume / acknowledge pulse
//   BTN_CLR     - abort and zero the time
//   BTN_UP      - +1 minute while in SETUP
//   BTN_DOWN    - -1 minute while in SETUP
//   SEC_L/SEC_H - seconds units / tens
//   MIN_L/MIN_H - minutes units / tens
//   RUNNING     - high while counting down
//   ALARM       - high once the countdown has reached 00:00
// Button priority in every cycle is CLR > START > UP > DOWN.
module up2_timer_ctrl
   import timer_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int DIV_W    = 26
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               BTN_START,
   input  logic               BTN_CLR,
   input  logic               BTN_UP,
   input  logic               BTN_DOWN,
   output logic [UNITS_W-1:0] SEC_L,
   output logic [TENS_W-1:0]  SEC_H,
   output logic [UNITS_W-1:0] MIN_L,
   output logic [TENS_W-1:0]  MIN_H,
   output logic               RUNNING,
   output logic               ALARM
);

   state_t           state;
   logic [DIV_W-1:0] presc;

   logic presc_wrap;
   logic tick;
   logic min_up;
   logic min_dn;
   logic time_zero;
   logic time_one;

   logic sec_l_tcu, sec_l_tcd;
   logic sec_h_tcu, sec_h_tcd;
   logic min_l_tcu, min_l_tcd;
   logic min_h_tcu, min_h_tcd;

   assign presc_wrap = (presc == DIV_W'(TICK_DIV - 1));
   assign time_zero  = (MIN_H == '0) && (MIN_L == '0) && (SEC_H == '0) && (SEC_L == '0);
   assign time_one   = (MIN_H == '0) && (MIN_L == '0) && (SEC_H == '0) && (SEC_L == 4'd1);

   // A tick only happens on a RUN cycle that is not consumed by a higher
   // priority button; minute adjust only in SETUP with no CLR/START present.
   always_comb begin
      tick   = 1'b0;
      min_up = 1'b0;
      min_dn = 1'b0;
      if (!BTN_CLR && !BTN_START) begin
         tick   = (state == RUN) && presc_wrap;
         min_up = (state == SETUP) && BTN_UP && !BTN_DOWN;
         min_dn = (state == SETUP) && BTN_DOWN && !BTN_UP;
      end
   end

   // Seconds never count up; the up path exists only to carry minute
   // adjustments from MIN_L into MIN_H.
   up2_digit #(.N(UNITS_MOD), .SIZE(UNITS_W)) u_sec_l (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .EN_INC (1'b0),
      .EN_DEC (tick),
      .CLR    (BTN_CLR),
      .Q      (SEC_L),
      .TC_UP  (sec_l_tcu),
      .TC_DN  (sec_l_tcd)
   );

   up2_digit #(.N(TENS_MOD), .SIZE(TENS_W)) u_sec_h (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .EN_INC (sec_l_tcu),
      .EN_DEC (sec_l_tcd),
      .CLR    (BTN_CLR),
      .Q      (SEC_H),
      .TC_UP  (sec_h_tcu),
      .TC_DN  (sec_h_tcd)
   );

   up2_digit #(.N(UNITS_MOD), .SIZE(UNITS_W)) u_min_l (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .EN_INC (sec_h_tcu | min_up),
      .EN_DEC (sec_h_tcd | min_dn),
      .CLR    (BTN_CLR),
      .Q      (MIN_L),
      .TC_UP  (min_l_tcu),
      .TC_DN  (min_l_tcd)
   );

   // MIN_H wrapping 5 -> 0 (up) or 0 -> 5 (down) gives the mod-60 minutes.
   up2_digit #(.N(TENS_MOD), .SIZE(TENS_W)) u_min_h (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .EN_INC (min_l_tcu),
      .EN_DEC (min_l_tcd),
      .CLR    (BTN_CLR),
      .Q      (MIN_H),
      .TC_UP  (min_h_tcu),
      .TC_DN  (min_h_tcd)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= SETUP;
         presc <= '0;
      end else if (BTN_CLR) begin
         state <= SETUP;
         presc <= '0;
      end else begin
         case (state)
            SETUP: begin
               if (BTN_START && !time_zero) begin
                  state <= RUN;
                  presc <= '0;
               end
            end
            RUN: begin
               if (BTN_START) begin
                  // Pause holds the prescaler so resume loses no cycles.
                  state <= PAUSE;
               end else if (presc_wrap) begin
                  presc <= '0;
                  if (time_one) state <= DONE;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            PAUSE: begin
               if (BTN_START) state <= RUN;
            end
            DONE: begin
               if (BTN_START) state <= SETUP;
            end
            default: state <= SETUP;
         endcase
      end
   end

   assign RUNNING = (state == RUN);
   assign ALARM   = (state == DONE);

endmodule

// File: tb/tb_up2_timer_ctrl.sv
// Scoreboard bench for up2_timer_ctrl with TICK_DIV=4.
// The driver applies one button set per cycle, advances a seconds-based
// reference model and queues the expected outputs; the monitor pops one
// entry after every rising edge and compares.
module tb_up2_timer_ctrl;

   localparam int TICK_DIV = 4;
   localparam int DIV_W    = 2;

   logic       clk;
   logic       rst_n;
   logic       btn_start, btn_clr, btn_up, btn_down;
   logic [3:0] sec_l, min_l;
   logic [2:0] sec_h, min_h;
   logic       running, alarm;

   up2_timer_ctrl #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .BTN_START (btn_start),
      .BTN_CLR   (btn_clr),
      .BTN_UP    (btn_up),
      .BTN_DOWN  (btn_down),
      .SEC_L     (sec_l),
      .SEC_H     (sec_h),
      .MIN_L     (min_l),
      .MIN_H     (min_h),
      .RUNNING   (running),
      .ALARM     (alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: time kept as total seconds, mode as a small int.
   localparam int M_SETUP = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   int m_mode;
   int m_secs;
   int m_phase;   // RUN cycles counted since the last tick

   typedef struct {
      logic [15:0] val;
      string       tag;
   } exp_t;
   exp_t sb_q[$];
   string cur_tag;

   int n_cmp;
   int n_bad;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got mm:ss=%0d%0d:%0d%0d run=%0b alm=%0b, want mm:ss=%0d%0d:%0d%0d run=%0b alm=%0b",
                  name, act[15:13], act[12:9], act[8:6], act[5:2], act[1], act[0],
                  exp[15:13], exp[12:9], exp[8:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   function automatic logic [15:0] model_outputs();
      int mm, ss;
      logic [15:0] v;
      mm = m_secs / 60;
      ss = m_secs % 60;
      v[15:13] = 3'(mm / 10);
      v[12:9]  = 4'(mm % 10);
      v[8:6]   = 3'(ss / 10);
      v[5:2]   = 4'(ss % 10);
      v[1]     = (m_mode == M_RUN);
      v[0]     = (m_mode == M_DONE);
      return v;
   endfunction

   function automatic logic [15:0] dut_outputs();
      return {min_h, min_l, sec_h, sec_l, running, alarm};
   endfunction

   task automatic model_reset();
      m_mode  = M_SETUP;
      m_secs  = 0;
      m_phase = 0;
   endtask

   // Effect of one clock edge with the given buttons.
   task automatic model_step(input logic s, input logic c, input logic u, input logic d);
      int mm, ss;
      mm = m_secs / 60;
      ss = m_secs % 60;
      if (c) begin
         m_mode  = M_SETUP;
         m_secs  = 0;
         m_phase = 0;
      end else begin
         case (m_mode)
            M_SETUP: begin
               if (s) begin
                  if (m_secs != 0) begin
                     m_mode  = M_RUN;
                     m_phase = 0;
                  end
               end else if (u && !d) begin
                  m_secs = ((mm + 1) % 60) * 60 + ss;
               end else if (d && !u) begin
                  m_secs = ((mm + 59) % 60) * 60 + ss;
               end
            end
            M_RUN: begin
               if (s) begin
                  m_mode = M_PAUSE;
               end else begin
                  m_phase++;
                  if (m_phase == TICK_DIV) begin
                     m_phase = 0;
                     m_secs  = m_secs - 1;
                     if (m_secs == 0) m_mode = M_DONE;
                  end
               end
            end
            M_PAUSE: if (s) m_mode = M_RUN;
            default: if (s) m_mode = M_SETUP;
         endcase
      end
   endtask

   // Drive one cycle of buttons on the falling edge and queue the result.
   task automatic step(input logic s, input logic c, input logic u, input logic d);
      exp_t e;
      @(negedge clk);
      btn_start = s;
      btn_clr   = c;
      btn_up    = u;
      btn_down  = d;
      model_step(s, c, u, d);
      e.val = model_outputs();
      e.tag = cur_tag;
      sb_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic set_minutes(input int mins);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < mins; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Monitor: one expected entry per rising edge, sampled 1 time unit later.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check(e.tag, dut_outputs(), e.val);
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      cur_tag = "init";
      btn_start = 1'b0; btn_clr = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-simulation, then SETUP adjust.
      cur_tag = "setup_adj";
      idle(2);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_async", dut_outputs(), 16'h0000);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cur_tag = "min_wrap";
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Cascade 01:00 -> 00:59 and 10:00 -> 09:59.
      cur_tag = "cascade_1";
      set_minutes(1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      cur_tag = "cascade_10";
      set_minutes(10);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(5);

      // Expiry and acknowledge.
      cur_tag = "expiry";
      set_minutes(1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(240);
      idle(8);
      cur_tag = "ack";
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);

      // Pause and resume keep the prescaler phase.
      cur_tag = "pause";
      set_minutes(1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(10);
      cur_tag = "resume";
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Abort: CLR beats START; UP/DOWN ignored in RUN.
      cur_tag = "run_updown";
      set_minutes(2);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      cur_tag = "abort";
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);

      // Reset between edges while running at 00:37.
      cur_tag = "to_0037";
      set_minutes(1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(23 * TICK_DIV);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_mid_run", dut_outputs(), 16'h0000);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized button traffic.
      cur_tag = "random";
      for (int i = 0; i < 4000; i++) begin
         logic s, c, u, d;
         c = ($urandom_range(0, 199) == 0);
         s = ($urandom_range(0, 39) == 0);
         u = ($urandom_range(0, 9) == 0);
         d = ($urandom_range(0, 14) == 0);
         step(s, c, u, d);
      end

      step(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d entries left, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/up2_timer_ctrl.md
# up2_timer_ctrl

MM:SS countdown timer controller for the up2_timer design. It owns the four time digits and the run/pause/alarm state machine, and derives a one-second tick from the system clock. It decrements the time with a borrow cascade across digits and flags expiry. The four digits are held in four instances of a synchronous enable-driven modulo counter, sequenced entirely by this block.

## Interface
- TICK_DIV, default 50_000_000: CLK cycles per one-second tick (≥2).
- DIV_W, default 26: prescaler width, ≥ clog2(TICK_DIV).
- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- BTN_START  in  1  single-cycle pulse, synchronous, already debounced: start / pause / resume / acknowledge.
- BTN_CLR  in  1  single-cycle pulse: abort and zero the time.
- BTN_UP  in  1  single-cycle pulse: +1 minute in SETUP.
- BTN_DOWN  in  1  single-cycle pulse: −1 minute in SETUP.
- SEC_L  out  4  seconds units, 0..9.
- SEC_H  out  3  seconds tens, 0..5.
- MIN_L  out  4  minutes units, 0..9.
- MIN_H  out  3  minutes tens, 0..5.
- RUNNING  out  1  high while in RUN.
- ALARM  out  1  high while in DONE.

## Operation
- All outputs are registered or state-decoded. Reset (RST_N low, async) gives:
  - state SETUP;
  - all digits 0, prescaler 0;
  - RUNNING 0, ALARM 0.
- States: SETUP, RUN, PAUSE, DONE. Button priority per cycle: CLR > START > UP > DOWN.
- SETUP:
  - UP: minutes +1, mod 60 (59→00), seconds unchanged.
  - DOWN: minutes −1, mod 60 (00→59).
  - UP and DOWN in the same cycle: no change.
  - START with time ≠ 00:00: go to RUN, prescaler cleared to 0. START with time = 00:00 is ignored.
  - CLR: zero all digits.
- RUN, each cycle:
  - If prescaler = TICK_DIV−1: prescaler goes to 0 and a tick decrements the time by 1 s.
  - Otherwise the prescaler increments.
  - START goes to PAUSE; the current cycle does not count or tick.
  - CLR goes to SETUP with time 00:00.
  - UP and DOWN are ignored.
- Decrement cascade:
  - SEC_L 0→9 borrows from SEC_H; SEC_H 0→5 borrows from MIN_L; MIN_L 0→9 borrows from MIN_H.
  - The whole cascade resolves in the same cycle; no intermediate value is ever visible.
- Tick that makes the time 00:00: on the same edge, state goes to DONE. The time never decrements below 00:00.
- PAUSE:
  - Prescaler and digits are held, not cleared.
  - START goes to RUN and continues from the held prescaler value.
  - CLR goes to SETUP with time 00:00. UP and DOWN are ignored.
- DONE:
  - Time held at 00:00.
  - START or CLR goes to SETUP. Other buttons are ignored.
- Async reset mid-operation overrides everything and returns to the reset values immediately.

## Timing
- Button pulse sampled at edge k: state, digits and flags show the effect from edge k onward, visible in cycle k+1.
- RUNNING and ALARM are decoded from the state register, so they change on the same edge as the state.
- First tick after START from SETUP lands on the TICK_DIV-th RUN edge.
- Pause and resume lose no prescaler cycles: total RUN edges between ticks is always TICK_DIV.
- Expiry: time reads 00:00 and ALARM=1 from the same edge.
- No combinational path from inputs to outputs.

## Structure
- Package timer_pkg holds:
  - the state encoding constants (SETUP, RUN, PAUSE, DONE; 2 bits);
  - digit moduli: 10 for units, 6 for tens.
- Sub-module up2_digit, one instance per digit. Parameters N and SIZE. Ports:
  - CLK, RST_N;
  - EN_INC, EN_DEC, CLR;
  - Q;
  - combinational TC_UP (Q=N−1 and EN_INC) and TC_DN (Q=0 and EN_DEC), used to chain the cascade within one cycle.
- Controller top: FSM, prescaler, and the enable/borrow chaining between the four up2_digit instances.

## Test plan
All scenarios run with TICK_DIV=4 and DIV_W=2.

- Reset and SETUP adjust: assert RST_N=0 mid-simulation, then release.
  - Expect all digits 0, RUNNING=0, ALARM=0.
  - Apply UP×3: expect MIN 03.
  - From 00, apply DOWN: expect MIN 59 with SEC unchanged. UP and DOWN together: no change.
- Cascade: set 01:00, then START.
  - Expect 00:59 (MIN_H=0, MIN_L=0, SEC_H=5, SEC_L=9) after exactly 4 RUN edges.
  - Set 10:00, START: after the first tick expect 09:59.
- Expiry: set 01:00, START.
  - After 240 edges expect 00:00, ALARM=1, RUNNING=0, with no further decrement.
  - START then gives ALARM=0 and state SETUP.
  - START at 00:00 in SETUP: RUNNING stays 0.
- Pause: set 01:00, START, run 2 edges, START (pause), wait 10 edges.
  - Expect no digit change while paused.
  - START (resume): expect 00:59 after exactly 2 more RUN edges.
- Abort: during RUN, pulse CLR together with START.
  - CLR wins: expect SETUP, 00:00, RUNNING=0.
  - In RUN, UP or DOWN pulses change nothing.
- Reset mid-run: drop RST_N asynchronously between edges while in RUN at 00:37.
  - Outputs go to 00:00, RUNNING=0 before the next edge.
